blink_tick_gen: RTL and testbench

- Upstream stage of the LED blinker: produces the single-cycle toggle strobe the blinker consumes, replacing its fixed hard-wired 50 000 000-cycle count.
- A push button cycles the blink rate through four programmable periods.
- The raw button is synchronised, debounced and edge-detected in this block.
- Outputs: a tick strobe, the current rate index and a press pulse for board LEDs/debug.

---
 rtl/blink_tick_gen.sv | 110 +++++++++++
 tb/tb_blink_tick_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/blink_tick_gen.sv
// blink_tick_gen: rate-selectable tick strobe for the LED blinker.
// Ports: clk, rst (sync, active-high), btn_in (raw button), enable,
//   tick (1-cycle strobe), rate_sel (0..3), btn_pressed (1-cycle pulse).
module blink_tick_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned PERIOD0         = 50000000,
   parameter int unsigned PERIOD1         = 25000000,
   parameter int unsigned PERIOD2         = 12500000,
   parameter int unsigned PERIOD3         = 6250000,
   parameter int unsigned CNT_W           = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   input  logic       enable,
   output logic       tick,
   output logic [1:0] rate_sel,
   output logic       btn_pressed
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] P0_LAST = CNT_W'(PERIOD0 - 1);
   localparam logic [CNT_W-1:0] P1_LAST = CNT_W'(PERIOD1 - 1);
   localparam logic [CNT_W-1:0] P2_LAST = CNT_W'(PERIOD2 - 1);
   localparam logic [CNT_W-1:0] P3_LAST = CNT_W'(PERIOD3 - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             db_q, db_d;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
   logic             pressed_q, pressed_d;
   logic [1:0]       rate_q, rate_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] period_last;

   always_comb begin
      period_last = P0_LAST;
      unique case (rate_q)
         2'd0: period_last = P0_LAST;
         2'd1: period_last = P1_LAST;
         2'd2: period_last = P2_LAST;
         2'd3: period_last = P3_LAST;
         default: period_last = P0_LAST;
      endcase
   end

   always_comb begin
      sync1_d    = btn_in;
      sync2_d    = sync1_q;
      db_d       = db_q;
      db_cnt_d   = '0;
      rate_d     = rate_q;
      tick_cnt_d = tick_cnt_q;
      tick_d     = 1'b0;

      // Counter only advances while the synchronised level disagrees
      // with the accepted level; any agreeing cycle restarts it.
      if (sync2_q != db_q) begin
         if (db_cnt_q >= DB_LAST) begin
            db_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + CNT_W'(1);
         end
      end

      pressed_d = db_d & ~db_q;

      // A press takes priority over a coinciding terminal count.
      // The >= compare turns any out-of-range count into a wrap.
      if (pressed_q) begin
         rate_d     = rate_q + 2'd1;
         tick_cnt_d = '0;
      end else if (enable) begin
         if (tick_cnt_q >= period_last) begin
            tick_cnt_d = '0;
            tick_d     = 1'b1;
         end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         db_q       <= 1'b0;
         db_cnt_q   <= '0;
         pressed_q  <= 1'b0;
         rate_q     <= 2'd0;
         tick_cnt_q <= '0;
         tick_q     <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         db_q       <= db_d;
         db_cnt_q   <= db_cnt_d;
         pressed_q  <= pressed_d;
         rate_q     <= rate_d;
         tick_cnt_q <= tick_cnt_d;
         tick_q     <= tick_d;
      end
   end

   assign tick        = tick_q;
   assign rate_sel    = rate_q;
   assign btn_pressed = pressed_q;

endmodule

// File: tb/tb_blink_tick_gen.sv
// tb_blink_tick_gen: directed bench for blink_tick_gen.
// Small parameters: debounce 4, periods 8/6/4/2, 8-bit counters.
module tb_blink_tick_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_in;
   logic       enable;
   logic       tick;
   logic [1:0] rate_sel;
   logic       btn_pressed;

   blink_tick_gen #(
      .DEBOUNCE_CYCLES(4),
      .PERIOD0(8),
      .PERIOD1(6),
      .PERIOD2(4),
      .PERIOD3(2),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_in(btn_in),
      .enable(enable),
      .tick(tick),
      .rate_sel(rate_sel),
      .btn_pressed(btn_pressed)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         en;
      bit         btn;
      bit         tick;
      bit         pressed;
      logic [1:0] rate;
   } vec_t;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         tick_q[$];
   int         pr_q[$];
   logic [1:0] rate_h[0:255];
   vec_t       tbl[40];
   int         exp_t[$];
   int         exp_p[$];

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic chk_list(input string nm, input int got[$],
                           input int exp[$]);
      chk({nm, " count"}, got.size(), exp.size());
      for (int i = 0; i < got.size() && i < exp.size(); i++)
         chk($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
   endtask

   task automatic step(input bit en, input bit b);
      @(negedge clk);
      rst    = 1'b0;
      enable = en;
      btn_in = b;
      @(posedge clk);
      #1;
      cyc++;
      if (tick) tick_q.push_back(cyc);
      if (btn_pressed) pr_q.push_back(cyc);
      if (cyc < 256) rate_h[cyc] = rate_sel;
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      rst    = 1'b1;
      enable = 1'b0;
      btn_in = 1'b0;
      @(posedge clk);
      #1;
      chk({nm, " rst tick"}, int'(tick), 0);
      chk({nm, " rst pressed"}, int'(btn_pressed), 0);
      chk({nm, " rst rate"}, int'(rate_sel), 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      cyc = 0;
      tick_q.delete();
      pr_q.delete();
   endtask

   initial begin
      rst    = 1'b1;
      enable = 1'b0;
      btn_in = 1'b0;

      // Scenarios 1 and 2: free-running rate 0, then a 3-cycle glitch.
      for (int i = 0; i < 40; i++) begin
         tbl[i].en      = 1'b1;
         tbl[i].btn     = (i + 1 >= 25) && (i + 1 <= 27);
         tbl[i].tick    = ((i + 1) % 8) == 0;
         tbl[i].pressed = 1'b0;
         tbl[i].rate    = 2'd0;
      end
      do_reset("t1");
      for (int i = 0; i < 40; i++) begin
         step(tbl[i].en, tbl[i].btn);
         chk($sformatf("t1 tick@%0d", cyc), int'(tick), int'(tbl[i].tick));
         chk($sformatf("t1 press@%0d", cyc), int'(btn_pressed),
             int'(tbl[i].pressed));
         chk($sformatf("t1 rate@%0d", cyc), int'(rate_sel),
             int'(tbl[i].rate));
      end

      // Scenario 3: long hold gives one press, release gives none.
      do_reset("t3");
      for (int i = 0; i < 40; i++) step(1'b1, i < 20);
      exp_t = '{13, 19, 25, 31, 37};
      exp_p = '{6};
      chk_list("t3 ticks", tick_q, exp_t);
      chk_list("t3 press", pr_q, exp_p);
      chk("t3 rate@6", int'(rate_h[6]), 0);
      chk("t3 rate@7", int'(rate_h[7]), 1);
      chk("t3 rate@40", int'(rate_h[40]), 1);

      // Scenario 4: four presses cycle the rate 1,2,3,0.
      do_reset("t4");
      for (int p = 0; p < 4; p++)
         for (int i = 0; i < 30; i++) step(1'b1, i < 6);
      exp_t = '{13, 19, 25, 31, 41, 45, 49, 53, 57, 61, 65};
      for (int c = 69; c <= 95; c += 2) exp_t.push_back(c);
      exp_t.push_back(105);
      exp_t.push_back(113);
      exp_p = '{6, 36, 66, 96};
      chk_list("t4 ticks", tick_q, exp_t);
      chk_list("t4 press", pr_q, exp_p);
      chk("t4 rate@7", int'(rate_h[7]), 1);
      chk("t4 rate@37", int'(rate_h[37]), 2);
      chk("t4 rate@67", int'(rate_h[67]), 3);
      chk("t4 rate@96", int'(rate_h[96]), 3);
      chk("t4 rate@97", int'(rate_h[97]), 0);

      // Scenario 5: press lands on count 7 at rate 0.
      do_reset("t5");
      for (int i = 0; i < 30; i++) step(1'b1, (i >= 9) && (i < 15));
      exp_t = '{8, 22, 28};
      exp_p = '{15};
      chk_list("t5 ticks", tick_q, exp_t);
      chk_list("t5 press", pr_q, exp_p);
      chk("t5 rate@16", int'(rate_h[16]), 1);

      // Scenario 6: enable hold, then reset mid-period and mid-debounce.
      do_reset("t6");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0);
         chk($sformatf("t6 hold tick@%0d", cyc), int'(tick), 0);
      end
      for (int i = 0; i < 16; i++) step(1'b1, i >= 14);
      exp_t = '{13, 21};
      chk_list("t6 ticks", tick_q, exp_t);
      do_reset("t6b");
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      exp_t = '{8};
      exp_p = '{};
      chk_list("t6b ticks", tick_q, exp_t);
      chk_list("t6b press", pr_q, exp_p);
      chk("t6b rate", int'(rate_sel), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
